// File: rtl/word_bit_serializer.sv
// Parallel-to-serial feeder: a word accepted on in_valid&&in_ready shows its first bit on x_out the next cycle;
// out_en=0 freezes the frame and blocks acceptance. Define SER_PARITY_EN to append an even-parity bit.
module word_bit_serializer #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             out_en,
   output logic             x_out,
   output logic             x_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CW-1:0]    bit_cnt, bit_cnt_n;
   logic             x_out_n, x_valid_n, frame_start_n, frame_end_n;
   logic             xfer, do_load, do_idle;
`ifdef SER_PARITY_EN
   logic             par, par_n;
`endif

   function automatic logic lead_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] shift_on(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   // frame_end is only ever set while the last frame bit is on x_out
   assign in_ready = (state == IDLE) || (frame_end && out_en);
   assign xfer     = in_valid && in_ready;
   assign busy     = (state != IDLE);

   always_comb begin
      state_n       = state;
      shreg_n       = shreg;
      bit_cnt_n     = bit_cnt;
      x_out_n       = x_out;
      x_valid_n     = x_valid;
      frame_start_n = frame_start;
      frame_end_n   = frame_end;
      do_load       = 1'b0;
      do_idle       = 1'b0;
`ifdef SER_PARITY_EN
      par_n         = par;
`endif
      case (state)
         IDLE: do_load = xfer;
         SHIFT: begin
            if (out_en) begin
               if (bit_cnt != LAST_DATA) begin
                  x_out_n       = lead_bit(shreg);
                  shreg_n       = shift_on(shreg);
                  bit_cnt_n     = bit_cnt + 1'b1;
                  frame_start_n = 1'b0;
`ifdef SER_PARITY_EN
                  frame_end_n   = 1'b0;
`else
                  frame_end_n   = ((bit_cnt + 1'b1) == LAST_DATA);
`endif
               end else begin
`ifdef SER_PARITY_EN
                  state_n       = PARITY;
                  x_out_n       = par;
                  bit_cnt_n     = bit_cnt + 1'b1;
                  frame_start_n = 1'b0;
                  frame_end_n   = 1'b1;
`else
                  do_load = xfer;
                  do_idle = !xfer;
`endif
               end
            end
         end
`ifdef SER_PARITY_EN
         PARITY: begin
            if (out_en) begin
               do_load = xfer;
               do_idle = !xfer;
            end
         end
`endif
         default: state_n = IDLE;
      endcase

      // a load at end of frame keeps x_valid high so the stream stays contiguous
      if (do_load) begin
         state_n       = SHIFT;
         x_out_n       = lead_bit(in_data);
         shreg_n       = shift_on(in_data);
         bit_cnt_n     = '0;
         x_valid_n     = 1'b1;
         frame_start_n = 1'b1;
         frame_end_n   = 1'b0;
`ifdef SER_PARITY_EN
         par_n         = ^in_data;
`endif
      end
      if (do_idle) begin
         state_n       = IDLE;
         x_out_n       = IDLE_LEVEL;
         x_valid_n     = 1'b0;
         frame_start_n = 1'b0;
         frame_end_n   = 1'b0;
         bit_cnt_n     = '0;
         shreg_n       = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         x_out       <= IDLE_LEVEL;
         x_valid     <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
`ifdef SER_PARITY_EN
         par         <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         shreg       <= shreg_n;
         bit_cnt     <= bit_cnt_n;
         x_out       <= x_out_n;
         x_valid     <= x_valid_n;
         frame_start <= frame_start_n;
         frame_end   <= frame_end_n;
`ifdef SER_PARITY_EN
         par         <= par_n;
`endif
      end
   end

endmodule

// File: doc/word_bit_serializer.md
Name: word_bit_serializer

Overview:
- Upstream feeder for the serial sequence-detector stage.
- Accepts parallel words over a valid/ready handshake and emits them one bit per enabled cycle on a registered serial output (x_out), which drives the detector's serial input.
- Supports back-to-back words with no gap bit, a downstream stall enable, and selectable bit order.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0, value driven on x_out when no bit is valid.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  serializer can accept a word this cycle; combinational.
- out_en  input  1  downstream advance enable; 0 holds the current bit.
- x_out  output  1  serial bit; registered.
- x_valid  output  1  x_out carries a frame bit; registered.
- frame_start  output  1  high while x_out is the first bit of a word; registered.
- frame_end  output  1  high while x_out is the last bit of a frame; registered.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE, shift register and bit counter cleared.
  - x_out = IDLE_LEVEL; x_valid, frame_start, frame_end and busy = 0.
  - A word in flight is discarded; no partial frame resumes after reset release.
- States: IDLE, SHIFT (plus PARITY when the optional feature is enabled).
- Handshake:
  - Transfer occurs on a rising edge where in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==SHIFT && last frame bit presented && out_en).
  - in_data is ignored when no transfer occurs.
- IDLE → SHIFT on transfer:
  - Word is loaded into the shift register; bit_cnt = 0.
  - On the same edge, x_out = first bit, x_valid = 1, frame_start = 1.
  - Latency: first bit is visible 1 cycle after acceptance.
- SHIFT, out_en=1:
  - Next bit is presented and bit_cnt increments.
  - frame_start = 1 only for bit 0.
  - frame_end = 1 for the last frame bit (bit WIDTH-1 without parity).
- SHIFT, out_en=0:
  - x_out, x_valid, frame_start, frame_end and bit_cnt all hold.
  - in_ready = 0 unless the state is IDLE.
- End of frame, out_en=1 while the last bit is shown:
  - If a transfer occurs on the same edge, the new word loads and its first bit appears next cycle. Stream is contiguous, x_valid stays 1 and frame_start pulses.
  - Otherwise → IDLE: x_valid = 0, x_out = IDLE_LEVEL.
- Bit order: MSB_FIRST=1 shifts left and takes the MSB; MSB_FIRST=0 shifts right and takes the LSB.
- bit_cnt width: clog2(WIDTH+1). It never exceeds the frame length minus 1 and has no wrap beyond the frame.
- busy = (state != IDLE).

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits) is appended after the data bits, in state PARITY. Frame length = WIDTH+1.
  - frame_end marks the parity bit, not bit WIDTH-1.
  - in_ready back-to-back condition applies at the parity bit.
- Undefined: no PARITY state or logic is present; frame length = WIDTH.

Test Plan:
- Single word: WIDTH=8, MSB_FIRST=1, out_en=1, in_data=8'hB6 accepted at cycle 0 → x_out = 1,0,1,1,0,1,1,0 on cycles 1–8. x_valid=1 on cycles 1–8, frame_start at cycle 1, frame_end at cycle 8, x_valid=0 and x_out=0 at cycle 9.
- Back-to-back: 8'hB6 then 8'h0F, in_valid held high → in_ready=1 at cycle 8. 16 contiguous valid bits 10110110_00001111, frame_start at cycles 1 and 9.
- Stall: 8'hB6 with out_en=0 on cycles 3–5 → x_out holds 1 (bit index 2) for cycles 3–6 and in_ready=0 during the stall. Frame completes at cycle 11 with the correct sequence.
- LSB-first: MSB_FIRST=0, in_data=8'hB6 → x_out = 0,1,1,0,1,1,0,1.
- Reset mid-frame: assert reset asynchronously during bit 4 → outputs go to reset values immediately, before the next clock edge. After release, 8'h55 serializes cleanly from bit 0.
- SER_PARITY_EN defined, in_data=8'h07 → 9 valid bits 00000111 followed by 1, frame_end on the 9th bit. in_data=8'h03 → parity bit 0.
